// File: rtl/seq_truth_table_gate_if.sv
// Handshake and data bundle for the settling truth-table gate.
// The master side drives inputs and config; the slave side is the gate.
interface seq_truth_table_gate_if #(
   parameter int N_IN = 3
);
   localparam int TW = 2 ** N_IN;

   logic [N_IN-1:0] in_vec;
   logic            cfg_valid;
   logic [TW-1:0]   cfg_table;
   logic            cfg_ready;
   logic            out;
   logic            out_valid;
   logic            changed;

   modport master (
      output in_vec,
      output cfg_valid,
      output cfg_table,
      input  cfg_ready,
      input  out,
      input  out_valid,
      input  changed
   );

   modport slave (
      input  in_vec,
      input  cfg_valid,
      input  cfg_table,
      output cfg_ready,
      output out,
      output out_valid,
      output changed
   );
endinterface

// File: rtl/seq_truth_table_gate.sv
// Runtime-loadable N_IN-input truth-table gate whose registered output
// only follows inputs that have stayed stable for SETTLE cycles.
module seq_truth_table_gate #(
   parameter int                   N_IN     = 3,
   parameter int                   SETTLE   = 4,
   parameter logic [2**N_IN-1:0]   TT_RESET = 8'hD5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   seq_truth_table_gate_if.slave   bus
);
   localparam int TW = 2 ** N_IN;
   localparam int CW = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);
   localparam logic [CW-1:0] CNT_HIT = CW'(SETTLE - 1);

   typedef enum logic [1:0] {
      UNSETTLED,
      SETTLED,
      RELOAD
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tt_q, tt_d;
   logic [N_IN-1:0] in_last_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            out_q, out_d;
   logic            valid_q, valid_d;
   logic            chg_q, chg_d;
   logic            rdy_q, rdy_d;
   logic            moved;
   logic            accept;
   logic [TW-1:0]   settle_tt;

   // MSB of the table is the result for the all-zero input
   function automatic logic lookup(
      input logic [TW-1:0]   t,
      input logic [N_IN-1:0] idx
   );
      logic [TW-1:0] r;
      for (int i = 0; i < TW; i++) begin
         r[i] = t[TW-1-i];
      end
      return r[idx];
   endfunction

   assign moved     = bus.in_vec != in_last_q;
   assign accept    = bus.cfg_valid && rdy_q;
   assign settle_tt = accept ? bus.cfg_table : tt_q;

   always_comb begin
      state_d = state_q;
      tt_d    = tt_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      valid_d = valid_q;
      rdy_d   = rdy_q;

      if (moved) begin
         cnt_d = '0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (accept) begin
         tt_d = bus.cfg_table;
      end

      unique case (state_q)
         UNSETTLED: begin
            // a table accepted on the settle edge is the one applied
            if (!moved && cnt_q == CNT_HIT) begin
               out_d   = lookup(settle_tt, in_last_q);
               valid_d = 1'b1;
               state_d = SETTLED;
            end
         end
         SETTLED: begin
            if (moved) begin
               valid_d = 1'b0;
               state_d = UNSETTLED;
            end else if (accept) begin
               rdy_d   = 1'b0;
               state_d = RELOAD;
            end
         end
         RELOAD: begin
            out_d = lookup(tt_q, in_last_q);
            rdy_d = 1'b1;
            if (moved) begin
               valid_d = 1'b0;
               state_d = UNSETTLED;
            end else begin
               state_d = SETTLED;
            end
         end
         default: begin
            valid_d = 1'b0;
            rdy_d   = 1'b1;
            state_d = UNSETTLED;
         end
      endcase

      chg_d = out_d != out_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= UNSETTLED;
         tt_q      <= TT_RESET;
         in_last_q <= '0;
         cnt_q     <= '0;
         out_q     <= 1'b0;
         valid_q   <= 1'b0;
         chg_q     <= 1'b0;
         rdy_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         tt_q      <= tt_d;
         in_last_q <= bus.in_vec;
         cnt_q     <= cnt_d;
         out_q     <= out_d;
         valid_q   <= valid_d;
         chg_q     <= chg_d;
         rdy_q     <= rdy_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = valid_q;
   assign bus.changed   = chg_q;
   assign bus.cfg_ready = rdy_q;
endmodule

// File: tb/tb_seq_truth_table_gate.sv
// Randomised and directed bench for seq_truth_table_gate against a
// run-length based reference model.
module tb_seq_truth_table_gate;
   localparam int SETTLE = 4;
   localparam logic [7:0] TT_RST = 8'hD5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   seq_truth_table_gate_if #(.N_IN(3)) bus ();

   seq_truth_table_gate #(
      .N_IN(3),
      .SETTLE(SETTLE),
      .TT_RESET(TT_RST)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [7:0] m_tbl;
   logic [2:0] m_prev;
   int         m_run;
   logic       m_out, m_valid, m_chg, m_ready, m_reload;

   function automatic logic f(input logic [7:0] t, input logic [2:0] i);
      return t[7 - int'(i)];
   endfunction

   task automatic m_reset();
      m_tbl = TT_RST; m_prev = 3'd0; m_run = 0;
      m_out = 1'b0; m_valid = 1'b0; m_chg = 1'b0;
      m_ready = 1'b1; m_reload = 1'b0;
   endtask

   // one clock edge of the model: run = edges the current input has held
   task automatic m_edge();
      logic same, acc, old;
      same = (bus.in_vec == m_prev);
      m_run = same ? (m_run < 1000 ? m_run + 1 : m_run) : 0;
      acc = bus.cfg_valid && m_ready;
      old = m_out;
      if (m_reload) begin
         m_out = f(m_tbl, m_prev);
         m_ready = 1'b1;
         m_reload = 1'b0;
         m_valid = same;
      end else if (!m_valid) begin
         if (acc) m_tbl = bus.cfg_table;
         if (same && m_run == SETTLE) begin
            m_valid = 1'b1;
            m_out = f(m_tbl, m_prev);
         end
      end else begin
         if (acc) m_tbl = bus.cfg_table;
         if (!same) m_valid = 1'b0;
         else if (acc) begin
            m_reload = 1'b1;
            m_ready = 1'b0;
         end
      end
      m_chg = (m_out != old);
      m_prev = bus.in_vec;
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge();
      @(negedge clk);
   endtask

   task automatic drive(input logic [2:0] v, input logic cv, input logic [7:0] t);
      bus.in_vec = v;
      bus.cfg_valid = cv;
      bus.cfg_table = t;
   endtask

   task automatic test_reset();
      drive(3'd0, 1'b0, 8'h00);
      rst_n = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({bus.out, bus.out_valid, bus.changed, bus.cfg_ready} !== 4'b0001) begin
         bad++;
         $display("FAIL reset_hold got=%b want=0001",
                  {bus.out, bus.out_valid, bus.changed, bus.cfg_ready});
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         total++;
         if ({bus.out, bus.out_valid, bus.changed} !== {m_out, m_valid, m_chg}) begin
            bad++;
            $display("FAIL reset_model edge=%0d got=%b want=%b", k,
                     {bus.out, bus.out_valid, bus.changed}, {m_out, m_valid, m_chg});
         end
         if (k == 4) begin
            total++;
            if ({bus.out, bus.out_valid, bus.changed} !== 3'b111) begin
               bad++;
               $display("FAIL reset_settle4 got=%b want=111",
                        {bus.out, bus.out_valid, bus.changed});
            end
         end
      end
   endtask

   task automatic test_sweep();
      bit exp_out [8] = '{1, 1, 0, 1, 0, 1, 0, 1};
      for (int v = 0; v < 8; v++) begin
         drive(3'(v), 1'b0, 8'h00);
         for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if ({bus.out, bus.out_valid, bus.changed, bus.cfg_ready} !==
                {m_out, m_valid, m_chg, m_ready}) begin
               bad++;
               $display("FAIL sweep_model v=%0d k=%0d got=%b want=%b", v, k,
                        {bus.out, bus.out_valid, bus.changed, bus.cfg_ready},
                        {m_out, m_valid, m_chg, m_ready});
            end
            if (v > 0 && k < 4) begin
               total++;
               if (bus.out_valid !== 1'b0) begin
                  bad++;
                  $display("FAIL sweep_unsettled v=%0d k=%0d got=%b want=0",
                           v, k, bus.out_valid);
               end
            end
         end
         total++;
         if (bus.out !== exp_out[v] || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL sweep_out v=%0d got=%b/%b want=%b/1", v,
                     bus.out, bus.out_valid, exp_out[v]);
         end
      end
   endtask

   task automatic test_glitch();
      logic [2:0] seq [10] = '{3, 3, 3, 3, 3, 3, 2, 2, 3, 3};
      for (int k = 0; k < 16; k++) begin
         drive(k < 10 ? seq[k] : 3'd3, 1'b0, 8'h00);
         tick();
         total++;
         if ({bus.out, bus.out_valid, bus.changed} !== {m_out, m_valid, m_chg} ||
             (k > 5 && bus.changed !== 1'b0)) begin
            bad++;
            $display("FAIL glitch k=%0d got=%b want=%b", k,
                     {bus.out, bus.out_valid, bus.changed}, {m_out, m_valid, m_chg});
         end
      end
      total++;
      if (bus.out !== 1'b1 || bus.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL glitch_end got=%b%b want=11", bus.out, bus.out_valid);
      end
   endtask

   task automatic test_reload();
      drive(3'd0, 1'b0, 8'h00);
      repeat (6) tick();
      drive(3'd0, 1'b1, 8'h2A);
      tick();
      total++;
      if ({bus.out, bus.out_valid, bus.changed, bus.cfg_ready} !== 4'b1100) begin
         bad++;
         $display("FAIL reload_enter got=%b want=1100",
                  {bus.out, bus.out_valid, bus.changed, bus.cfg_ready});
      end
      drive(3'd0, 1'b0, 8'h00);
      tick();
      total++;
      if ({bus.out, bus.out_valid, bus.changed, bus.cfg_ready} !== 4'b0111) begin
         bad++;
         $display("FAIL reload_exit got=%b want=0111",
                  {bus.out, bus.out_valid, bus.changed, bus.cfg_ready});
      end
      tick();
      total++;
      if ({bus.out, bus.out_valid, bus.changed, bus.cfg_ready} !==
          {m_out, m_valid, m_chg, m_ready} || bus.changed !== 1'b0) begin
         bad++;
         $display("FAIL reload_after got=%b want=%b",
                  {bus.out, bus.out_valid, bus.changed, bus.cfg_ready},
                  {m_out, m_valid, m_chg, m_ready});
      end
   endtask

   task automatic test_simul();
      drive(3'd2, 1'b1, 8'hFF);
      tick();
      total++;
      if ({bus.out_valid, bus.cfg_ready} !== 2'b01) begin
         bad++;
         $display("FAIL simul_accept got=%b want=01", {bus.out_valid, bus.cfg_ready});
      end
      drive(3'd2, 1'b0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         tick();
         total++;
         if ({bus.out, bus.out_valid, bus.changed, bus.cfg_ready} !==
             {m_out, m_valid, m_chg, m_ready} || bus.cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL simul_settle k=%0d got=%b want=%b", k,
                     {bus.out, bus.out_valid, bus.changed, bus.cfg_ready},
                     {m_out, m_valid, m_chg, m_ready});
         end
      end
      total++;
      if (bus.out !== 1'b1 || bus.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL simul_out got=%b%b want=11", bus.out, bus.out_valid);
      end
   endtask

   task automatic test_reset_reload();
      drive(3'd0, 1'b0, 8'h00);
      repeat (6) tick();
      drive(3'd0, 1'b1, 8'h00);
      tick();
      drive(3'd0, 1'b0, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      total++;
      if ({bus.out, bus.out_valid, bus.changed, bus.cfg_ready} !== 4'b0001) begin
         bad++;
         $display("FAIL reset_in_reload got=%b want=0001",
                  {bus.out, bus.out_valid, bus.changed, bus.cfg_ready});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) tick();
      total++;
      if (bus.out !== 1'b1 || bus.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL reset_table got=%b%b want=11", bus.out, bus.out_valid);
      end
   endtask

   task automatic test_random();
      logic [2:0] v;
      logic       cv;
      logic [7:0] t;
      v = 3'd0; cv = 1'b0; t = 8'h00;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 99) < 25) v = 3'($urandom_range(0, 7));
         if (cv && !bus.cfg_ready) cv = 1'b1;
         else if ($urandom_range(0, 99) < 12) begin
            cv = 1'b1;
            t = 8'($urandom);
         end else cv = 1'b0;
         drive(v, cv, t);
         tick();
         total++;
         if ({bus.out, bus.out_valid, bus.changed, bus.cfg_ready} !==
             {m_out, m_valid, m_chg, m_ready}) begin
            bad++;
            $display("FAIL random k=%0d got=%b want=%b", k,
                     {bus.out, bus.out_valid, bus.changed, bus.cfg_ready},
                     {m_out, m_valid, m_chg, m_ready});
         end
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_glitch();
      test_reload();
      test_simul();
      test_reset_reload();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seq_truth_table_gate.md
Name: seq_truth_table_gate

Overview:
- Parametrised, reconfigurable successor to the fixed 3-input truth-table gates.
- N_IN-input Boolean function whose truth table is a runtime-loadable register.
- Inputs must stay stable for a programmable settle time before the registered output updates. This models slow-responding gate outputs and filters input glitches.
- Sits between input sensors/upstream gates and downstream gate logic in the circuit netlist.

Parameters:
N_IN, 3, number of inputs (1..6)
SETTLE, 4, consecutive stable cycles required before output update (>=1, counter width clog2(SETTLE+1))
TT_RESET, 8'hD5, reset truth table, width 2**N_IN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_vec  in  N_IN  function inputs; in_vec[N_IN-1] is in1 (MSB of index)
cfg_valid  in  1  truth-table load request
cfg_table  in  2**N_IN  new truth table
cfg_ready  out  1  load accepted when cfg_valid && cfg_ready at rising edge
out  out  1  registered function output
out_valid  out  1  out reflects current settled input under current table
changed  out  1  one-cycle pulse when out toggles

Behaviour:
- Table mapping: idx = in_vec as unsigned; f(idx) = table[2**N_IN-1-idx]. The MSB of the table is the result for all-zero inputs. Default 'hD5 gives idx 0..7 -> 1,1,0,1,0,1,0,1.
- Reset (async assert, sync-free deassert), all registers:
  - out=0, out_valid=0, changed=0, cfg_ready=1
  - table=TT_RESET, in_last=0, cnt=0, state=UNSETTLED
- Every edge: in_last<=in_vec.
- Settle counter, per edge:
  - in_vec!=in_last -> cnt<=0
  - else cnt<cnt_max -> cnt<=cnt+1
  - else hold (saturates at SETTLE)
- States:
  - UNSETTLED: out holds last value, out_valid=0. On the edge where in_vec==in_last and cnt==SETTLE-1:
    - out<=f(in_last), out_valid<=1
    - changed<=1 iff the new value differs from old out
    - go SETTLED
  - SETTLED: out_valid=1. On the edge where in_vec!=in_last: out_valid<=0, go UNSETTLED, out unchanged.
  - RELOAD (one cycle, cfg_ready=0): at its exit edge, out<=f(in_last) using the new table, changed on difference.
    - If inputs are still stable, go SETTLED.
    - If in_vec!=in_last on that edge, go UNSETTLED with out_valid<=0.
- Latency: an input change first sampled at edge E0 produces an out update at edge E0+SETTLE, provided no further change occurs.
- Config handshake:
  - Accept at edge when cfg_valid&&cfg_ready; table<=cfg_table.
  - Accept in SETTLED -> go RELOAD (cfg_ready<=0 for one cycle), out_valid stays 1 holding the old value until the RELOAD exit edge.
  - Accept in UNSETTLED -> table updates, stay UNSETTLED, cfg_ready stays 1; the new table is used at settle.
  - Accept on the same edge as an input change in SETTLED -> table updates, go UNSETTLED (input change wins), no RELOAD.
  - cfg_valid while cfg_ready=0 is ignored; the requester must hold it.
- changed is high for exactly one cycle, only on edges where out toggles; never asserted by reset.
- Reset mid-settle or mid-RELOAD returns everything to reset values immediately; a pending config is discarded.
- Glitch shorter than SETTLE+1 sampled edges: no out change. out_valid drops for the glitch duration and returns when it resettles to the same value; changed stays 0.

Test Plan:
- Reset with in_vec=3'b000 held, SETTLE=4 -> out=0, out_valid=0 during reset. out=1, out_valid=1, changed pulses at edge 4 after rst_n release.
- Sweep in_vec 0..7, each held 8 cycles, default table -> settled outs 1,1,0,1,0,1,0,1. changed pulses only on transitions 1->0/0->1. out_valid low for 4 cycles after each change.
- Glitch: settled at in_vec=3'b011 (out=1), drive 3'b010 for 2 cycles then back -> out stays 1, changed never asserts, out_valid returns high.
- Reload while SETTLED at in_vec=3'b000: cfg_table=8'h2A accepted -> cfg_ready low one cycle, out 1->0 at the RELOAD exit edge, changed one pulse, out_valid stays high.
- Simultaneous accept of 8'hFF and in_vec change 3'b000->3'b010 -> state UNSETTLED, no RELOAD; after settle out=1.
- Assert rst_n=0 during RELOAD -> table back to 8'hD5, cfg_ready=1, out=0, out_valid=0 immediately.
